// File: rtl/wrr_hold_arbiter.sv
// Weighted round-robin arbiter with per-grant hold limit.
// One grant at a time; credits per round come from weight, reloaded when no requester has credit left.
module wrr_hold_arbiter #(
  parameter int N        = 4,
  parameter int WW       = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N-1:0]                        req,
  input  logic [N-1:0]                        last,
  input  logic [N*WW-1:0]                     weight,
  output logic [N-1:0]                        grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_id,
  output logic                                hold_timeout
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [N-1:0][WW-1:0]   credit_q, credit_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [N-1:0]           grant_q, grant_d;
  logic [IW-1:0]          id_q, id_d;
  logic                   to_q, to_d;

  logic [N-1:0]           credit_nz_s, eligible_s, cand_s;
  logic                   reload_s, found_s;
  logic [IW-1:0]          win_s;
  logic                   g_req_s, g_last_s, at_limit_s, txn_end_s;
  logic [IW-1:0]          next_ptr_s;

  function automatic logic [WW-1:0] eff_weight(input logic [WW-1:0] w);
    return (w == '0) ? WW'(1) : w;
  endfunction

  // Winner search: first candidate at or cyclically above the pointer
  always_comb begin
    logic [IW:0] sum;
    logic [IW:0] idx;
    for (int i = 0; i < N; i++) begin
      credit_nz_s[i] = (credit_q[i] != '0);
    end
    eligible_s = req & credit_nz_s;
    reload_s   = (eligible_s == '0) && (req != '0);
    cand_s     = reload_s ? req : eligible_s;
    found_s    = 1'b0;
    win_s      = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      idx = (sum >= (IW+1)'(N)) ? (sum - (IW+1)'(N)) : sum;
      if (!found_s && cand_s[idx[IW-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx[IW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // End-of-transaction conditions for the current holder
  always_comb begin
    g_req_s    = req[id_q];
    g_last_s   = last[id_q];
    at_limit_s = (hold_q == HOLD_LAST);
    txn_end_s  = !g_req_s || g_last_s || at_limit_s;
    next_ptr_s = (id_q == IW'(N - 1)) ? '0 : (id_q + IW'(1));
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (found_s) state_d = BUSY;
        else         state_d = IDLE;
      end
      BUSY: begin
        if (txn_end_s) state_d = IDLE;
        else           state_d = BUSY;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; credits reload before the winner's decrement
  always_comb begin
    credit_d = credit_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    grant_d  = grant_q;
    id_d     = id_q;
    to_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          for (int i = 0; i < N; i++) begin
            credit_d[i] = reload_s ? eff_weight(weight[i*WW +: WW]) : credit_q[i];
          end
          credit_d[win_s] = credit_d[win_s] - WW'(1);
          grant_d         = '0;
          grant_d[win_s]  = 1'b1;
          id_d            = win_s;
          hold_d          = '0;
        end else begin
          grant_d = '0;
          id_d    = '0;
        end
      end
      BUSY: begin
        if (txn_end_s) begin
          grant_d = '0;
          id_d    = '0;
          ptr_d   = next_ptr_s;
          to_d    = g_req_s && !g_last_s && at_limit_s;
        end else begin
          hold_d  = hold_q + HW'(1);
        end
      end
      default: begin
        grant_d = '0;
        id_d    = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q    <= '0;
      credit_q <= '0;
      hold_q   <= '0;
      grant_q  <= '0;
      id_q     <= '0;
      to_q     <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      hold_q   <= hold_d;
      grant_q  <= grant_d;
      id_q     <= id_d;
      to_q     <= to_d;
    end
  end

  assign grant        = grant_q;
  assign grant_id     = id_q;
  assign hold_timeout = to_q;

endmodule

// File: tb/tb_wrr_hold_arbiter.sv
// Self-checking bench for wrr_hold_arbiter: fixed vector table, directed corner sequences,
// and random traffic against a transaction-level reference model.
module tb_wrr_hold_arbiter;

  localparam int N        = 4;
  localparam int WW       = 4;
  localparam int MAX_HOLD = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*WW-1:0] weight;
  logic [N-1:0]    grant;
  logic [1:0]      grant_id;
  logic            hold_timeout;

  int nvec = 0;
  int nerr = 0;

  wrr_hold_arbiter #(.N(N), .WW(WW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .weight(weight),
    .grant(grant), .grant_id(grant_id), .hold_timeout(hold_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: who owns the bus, for how long, and how many turns each requester has left
  int         m_cred [N];
  int         m_ptr;
  bit         m_busy;
  int         m_own;
  int         m_hold;
  logic [3:0] m_grant;
  logic [1:0] m_id;
  logic       m_to;

  function automatic int turns_for(int i);
    int w;
    w = int'(weight[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cred[i] = 0;
    m_ptr = 0; m_busy = 0; m_own = 0; m_hold = 0;
    m_grant = 4'b0000; m_id = 2'd0; m_to = 1'b0;
  endtask

  task automatic model_step();
    bit any;
    bit done;
    int win;
    m_to = 1'b0;
    if (!m_busy) begin
      if (req != 4'b0000) begin
        any = 0;
        for (int i = 0; i < N; i++) if (req[i] && m_cred[i] > 0) any = 1;
        if (!any) for (int i = 0; i < N; i++) m_cred[i] = turns_for(i);
        win = -1;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (win < 0 && req[c] && m_cred[c] > 0) win = c;
        end
        m_cred[win] = m_cred[win] - 1;
        m_busy = 1; m_own = win; m_hold = 0;
        m_grant = 4'b0000; m_grant[win] = 1'b1; m_id = 2'(win);
      end
    end else begin
      done = 0;
      if (!req[m_own] || last[m_own]) done = 1;
      else if (m_hold == MAX_HOLD - 1) begin done = 1; m_to = 1'b1; end
      else m_hold = m_hold + 1;
      if (done) begin
        m_busy = 0; m_ptr = (m_own + 1) % N;
        m_grant = 4'b0000; m_id = 2'd0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("grant", 32'(grant), 32'(m_grant));
    chk("grant_id", 32'(grant_id), 32'(m_id));
    chk("hold_timeout", 32'(hold_timeout), 32'(m_to));
    chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    chk("grant_id_match", 32'((grant == 4'b0000) ? (grant_id == 2'd0) : grant[grant_id]), 32'd1);
  endtask

  // One clock: model follows the inputs sampled at the edge, outputs checked 1 time unit later
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;
  endtask

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] exp_grant;
    logic [1:0] exp_id;
  } vec_t;

  vec_t tbl [12];
  int   exp_ord [12];
  int   got_ord [$];
  logic [3:0] prev_grant;
  int   hi, to_cnt, to_at_drop;

  initial begin
    tbl[0]  = '{4'b0101, 4'b0000, 4'b0001, 2'd0};
    tbl[1]  = '{4'b0101, 4'b0000, 4'b0001, 2'd0};
    tbl[2]  = '{4'b0101, 4'b0001, 4'b0000, 2'd0};
    tbl[3]  = '{4'b0101, 4'b0000, 4'b0100, 2'd2};
    tbl[4]  = '{4'b0101, 4'b0000, 4'b0100, 2'd2};
    tbl[5]  = '{4'b0101, 4'b0100, 4'b0000, 2'd0};
    tbl[6]  = '{4'b0101, 4'b0000, 4'b0001, 2'd0};
    tbl[7]  = '{4'b0101, 4'b0000, 4'b0001, 2'd0};
    tbl[8]  = '{4'b0101, 4'b0001, 4'b0000, 2'd0};
    tbl[9]  = '{4'b0101, 4'b0000, 4'b0100, 2'd2};
    tbl[10] = '{4'b0101, 4'b0000, 4'b0100, 2'd2};
    tbl[11] = '{4'b0101, 4'b0100, 4'b0000, 2'd0};
    exp_ord = '{0, 1, 2, 3, 0, 0, 1, 2, 3, 0, 0, 0};

    req = 4'b0000; last = 4'b0000; weight = 16'h1111; rst = 1'b1;
    #2;
    do_reset();

    // Two requesters, unit weights, last one cycle after grant
    for (int r = 0; r < 12; r++) begin
      req = tbl[r].req; last = tbl[r].last;
      step();
      chk("tbl_grant", 32'(grant), 32'(tbl[r].exp_grant));
      chk("tbl_grant_id", 32'(grant_id), 32'(tbl[r].exp_id));
    end

    // Requester 0 weighted 3, everyone requesting, single-beat transactions
    req = 4'b0000; last = 4'b0000;
    do_reset();
    weight = 16'h1113; req = 4'b1111; last = 4'b1111;
    prev_grant = 4'b0000;
    for (int c = 0; c < 24; c++) begin
      step();
      if (grant != 4'b0000 && prev_grant == 4'b0000) got_ord.push_back(int'(grant_id));
      prev_grant = grant;
    end
    chk("wrr_grant_count", 32'(got_ord.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      chk("wrr_order", (i < got_ord.size()) ? 32'(got_ord[i]) : 32'hFFFF_FFFF, 32'(exp_ord[i]));
    end

    // Hold limit: requester 1 never signals last
    req = 4'b0000; last = 4'b0000;
    do_reset();
    weight = 16'h1111; req = 4'b0110; last = 4'b0000;
    step();
    chk("hold_first_grant", 32'(grant), 32'h2);
    hi = 1; to_cnt = 0; to_at_drop = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (hold_timeout) begin
        to_cnt++;
        to_at_drop = (grant == 4'b0000) ? 1 : 0;
      end
      if (grant == 4'b0010) hi++;
      else break;
    end
    chk("hold_cycles", 32'(hi), 32'(MAX_HOLD));
    chk("hold_timeout_pulses", 32'(to_cnt), 32'd1);
    chk("hold_timeout_at_drop", 32'(to_at_drop), 32'd1);
    step();
    chk("after_timeout_grant", 32'(grant), 32'h4);
    chk("after_timeout_pulse", 32'(hold_timeout), 32'd0);

    // Holder drops req without last; pointer must still advance
    req = 4'b0000; last = 4'b0000;
    do_reset();
    weight = 16'h2222; req = 4'b0001; last = 4'b0000;
    step();
    chk("drop_grant0", 32'(grant), 32'h1);
    step();
    req = 4'b0000;
    step();
    chk("drop_cleared", 32'(grant), 32'h0);
    chk("drop_no_timeout", 32'(hold_timeout), 32'd0);
    req = 4'b1001;
    step();
    chk("drop_ptr_advanced", 32'(grant), 32'h8);
    chk("drop_ptr_id", 32'(grant_id), 32'd3);

    // Reset in the middle of a grant to requester 2
    req = 4'b0000; last = 4'b0000;
    do_reset();
    weight = 16'h1111; req = 4'b0100; last = 4'b0000;
    step();
    chk("rst_pre_grant", 32'(grant), 32'h4);
    step();
    do_reset();
    chk("rst_grant_zero", 32'(grant), 32'h0);
    step();
    chk("rst_regrant", 32'(grant), 32'h4);
    chk("rst_regrant_id", 32'(grant_id), 32'd2);

    // Random traffic against the model
    req = 4'b0000; last = 4'b0000;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      last = 4'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) weight = 16'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
